// File: rtl/match_array_pipe_pkg.sv
// Shared definitions for the pipelined N-channel comparator.
// Compare-mode encoding is shared with the branch unit.
package match_array_pipe_pkg;

   typedef enum logic [1:0] {
      CMP_EQ  = 2'b00,
      CMP_NE  = 2'b01,
      CMP_LTU = 2'b10,
      CMP_LT  = 2'b11
   } cmp_mode_e;

endpackage

// File: rtl/match_array_pipe_cmp_cell.sv
// Single-channel combinational comparator: a is the candidate, b is the key.
// LTU/LT test a < b.
module cmp_cell
   import match_array_pipe_pkg::*;
#(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [1:0]   mode,
   output logic         m
);

   always_comb begin
      m = 1'b0;
      case (cmp_mode_e'(mode))
         CMP_EQ:  m = (a == b);
         CMP_NE:  m = (a != b);
         CMP_LTU: m = (a < b);
         CMP_LT:  m = ($signed(a) < $signed(b));
         default: m = 1'b0;
      endcase
   end

endmodule

// File: rtl/match_array_pipe.sv
// Two-stage valid/ready comparator: S1 holds the per-channel match vector,
// S2 holds the reduced response (hit / lowest index / multi-hit).
module match_array_pipe
   import match_array_pipe_pkg::*;
#(
   parameter  int W     = 32,
   parameter  int N     = 4,
   parameter  int CNT_W = 16,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [1:0]         req_mode,
   input  logic [W-1:0]       req_key,
   input  logic [N*W-1:0]     req_cand,
   input  logic [N-1:0]       req_cvld,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [N-1:0]       rsp_match,
   output logic               rsp_hit,
   output logic [IDX_W-1:0]   rsp_idx,
   output logic               rsp_multi,
   input  logic               cnt_clr,
   output logic [CNT_W-1:0]   hit_cnt
);

   logic [N-1:0]     raw_match;
   logic             s1_valid;
   logic [N-1:0]     s1_match;
   logic             s1_en;
   logic             s2_en;
   logic [IDX_W-1:0] red_idx;
   logic             red_multi;
   logic             red_seen;

   for (genvar i = 0; i < N; i++) begin : g_cell
      cmp_cell #(.W(W)) u_cell (
         .a    (req_cand[i*W +: W]),
         .b    (req_key),
         .mode (req_mode),
         .m    (raw_match[i])
      );
   end

   assign s2_en     = !rsp_valid || rsp_ready;
   assign s1_en     = !s1_valid || s2_en;
   assign req_ready = s1_en;

   // First set bit gives the index; any later set bit means multi-hit.
   always_comb begin
      red_idx   = '0;
      red_multi = 1'b0;
      red_seen  = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (s1_match[i]) begin
            if (!red_seen) red_idx = IDX_W'(i);
            else           red_multi = 1'b1;
            red_seen = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_match <= '0;
      end else if (s1_en) begin
         s1_valid <= req_valid;
         if (req_valid) s1_match <= raw_match & req_cvld;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_match <= '0;
         rsp_hit   <= 1'b0;
         rsp_idx   <= '0;
         rsp_multi <= 1'b0;
      end else if (s2_en) begin
         rsp_valid <= s1_valid;
         if (s1_valid) begin
            rsp_match <= s1_match;
            rsp_hit   <= |s1_match;
            rsp_idx   <= red_idx;
            rsp_multi <= red_multi;
         end
      end
   end

   // Clear has priority over a coincident increment; the count saturates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt <= '0;
      end else if (cnt_clr) begin
         hit_cnt <= '0;
      end else if (rsp_valid && rsp_ready && rsp_hit && (hit_cnt != '1)) begin
         hit_cnt <= hit_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_match_array_pipe.sv
// Self-checking bench: directed table, counter/backpressure/reset sequences
// and a randomized stream checked against a behavioural scoreboard.
module tb_match_array_pipe;

   localparam logic [1:0] M_EQ = 2'b00, M_NE = 2'b01, M_LTU = 2'b10, M_LT = 2'b11;

   typedef struct packed {
      logic [3:0] match;
      logic       hit;
      logic [1:0] idx;
      logic       multi;
   } rsp_t;

   typedef struct {
      logic [1:0]   mode;
      logic [31:0]  key;
      logic [127:0] cand;
      logic [3:0]   cvld;
      rsp_t         exp;
   } vec_t;

   logic         clk, rst_n;
   logic         req_valid, req_ready, rsp_valid, rsp_ready, cnt_clr;
   logic [1:0]   req_mode;
   logic [31:0]  req_key;
   logic [127:0] req_cand;
   logic [3:0]   req_cvld, rsp_match;
   logic         rsp_hit, rsp_multi;
   logic [1:0]   rsp_idx;
   logic [15:0]  hit_cnt;

   logic         s_req_ready, s_rsp_valid, s_rsp_hit, s_rsp_multi;
   logic [3:0]   s_rsp_match;
   logic [1:0]   s_rsp_idx, s_hit_cnt;

   logic         o_req_ready, o_rsp_valid, o_rsp_hit, o_rsp_multi;
   logic [0:0]   o_rsp_match, o_rsp_idx;
   logic [15:0]  o_hit_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   int n_rsp = 0;
   rsp_t exp_q[$];
   int cnt_m, cnt_s, cnt_o;

   match_array_pipe #(.W(32), .N(4), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_mode(req_mode), .req_key(req_key), .req_cand(req_cand), .req_cvld(req_cvld),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_match(rsp_match), .rsp_hit(rsp_hit),
      .rsp_idx(rsp_idx), .rsp_multi(rsp_multi), .cnt_clr(cnt_clr), .hit_cnt(hit_cnt));

   match_array_pipe #(.W(32), .N(4), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(s_req_ready),
      .req_mode(req_mode), .req_key(req_key), .req_cand(req_cand), .req_cvld(req_cvld),
      .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_match(s_rsp_match), .rsp_hit(s_rsp_hit),
      .rsp_idx(s_rsp_idx), .rsp_multi(s_rsp_multi), .cnt_clr(cnt_clr), .hit_cnt(s_hit_cnt));

   match_array_pipe #(.W(32), .N(1), .CNT_W(16)) dut_one (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(o_req_ready),
      .req_mode(req_mode), .req_key(req_key), .req_cand(req_cand[31:0]), .req_cvld(req_cvld[0:0]),
      .rsp_valid(o_rsp_valid), .rsp_ready(rsp_ready), .rsp_match(o_rsp_match), .rsp_hit(o_rsp_hit),
      .rsp_idx(o_rsp_idx), .rsp_multi(o_rsp_multi), .cnt_clr(cnt_clr), .hit_cnt(o_hit_cnt));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: evaluate each channel from the mode's arithmetic meaning.
   function automatic rsp_t model(input logic [1:0] mode, input logic [31:0] key,
                                  input logic [127:0] cand, input logic [3:0] cvld);
      rsp_t r;
      logic [31:0] c;
      logic        t;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         c = cand[i*32 +: 32];
         case (mode)
            M_EQ:    t = (c == key);
            M_NE:    t = (c != key);
            M_LTU:   t = (longint'({32'b0, c}) < longint'({32'b0, key}));
            default: t = (int'(c) < int'(key));
         endcase
         r.match[i] = t && cvld[i];
      end
      r.hit = (r.match != 4'b0);
      for (int i = 3; i >= 0; i--) if (r.match[i]) r.idx = 2'(i);
      r.multi = ($countones(r.match) >= 2);
      return r;
   endfunction

   rsp_t mon_e, held;
   logic held_valid;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         cnt_m = 0; cnt_s = 0; cnt_o = 0;
         held_valid = 1'b0;
      end else begin
         chk("hit_cnt", 64'(hit_cnt), 64'(cnt_m));
         chk("hit_cnt_sat", 64'(s_hit_cnt), 64'(cnt_s));
         chk("hit_cnt_n1", 64'(o_hit_cnt), 64'(cnt_o));
         if (held_valid) begin
            chk("stall_valid", 64'(rsp_valid), 64'd1);
            chk("stall_rsp", 64'({rsp_match, rsp_hit, rsp_idx, rsp_multi}), 64'(held));
         end
         mon_e = '0;
         if (rsp_valid && rsp_ready) begin
            n_rsp++;
            if (exp_q.size() == 0) begin
               chk("unexpected_rsp", 64'd1, 64'd0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("rsp", 64'({rsp_match, rsp_hit, rsp_idx, rsp_multi}), 64'(mon_e));
               chk("rsp_sat", 64'({s_rsp_valid, s_rsp_match}), 64'({1'b1, mon_e.match}));
               chk("rsp_n1", 64'({o_rsp_valid, o_rsp_match, o_rsp_hit, o_rsp_idx, o_rsp_multi}),
                   64'({1'b1, mon_e.match[0], mon_e.match[0], 1'b0, 1'b0}));
            end
         end
         if (req_valid && req_ready) exp_q.push_back(model(req_mode, req_key, req_cand, req_cvld));
         held_valid = rsp_valid && !rsp_ready;
         held = {rsp_match, rsp_hit, rsp_idx, rsp_multi};
         if (cnt_clr) begin
            cnt_m = 0; cnt_s = 0; cnt_o = 0;
         end else if (rsp_valid && rsp_ready) begin
            if (mon_e.hit && cnt_m < 65535) cnt_m++;
            if (mon_e.hit && cnt_s < 3) cnt_s++;
            if (mon_e.match[0] && cnt_o < 65535) cnt_o++;
         end
      end
   end

   task automatic drive(input vec_t v);
      req_valid = 1'b1;
      req_mode  = v.mode;
      req_key   = v.key;
      req_cand  = v.cand;
      req_cvld  = v.cvld;
   endtask

   // Called at posedge+1 with an empty S1; checks the two-cycle latency.
   task automatic send_one(input vec_t v, input string tag);
      rsp_ready = 1'b1;
      drive(v);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk({tag, "_lat1"}, 64'(rsp_valid), 64'd0);
      @(posedge clk); #1;
      chk({tag, "_valid"}, 64'(rsp_valid), 64'd1);
      chk({tag, "_match"}, 64'(rsp_match), 64'(v.exp.match));
      chk({tag, "_hit"},   64'(rsp_hit),   64'(v.exp.hit));
      chk({tag, "_idx"},   64'(rsp_idx),   64'(v.exp.idx));
      chk({tag, "_multi"}, 64'(rsp_multi), 64'(v.exp.multi));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #3;
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   function automatic vec_t rand_vec();
      vec_t v;
      v.mode = 2'($urandom_range(0, 3));
      v.key  = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      for (int i = 0; i < 4; i++) begin
         case ($urandom_range(0, 3))
            0: v.cand[i*32 +: 32] = v.key;
            1: v.cand[i*32 +: 32] = v.key + 32'd1;
            2: v.cand[i*32 +: 32] = v.key - 32'd1;
            default: v.cand[i*32 +: 32] = $urandom;
         endcase
      end
      v.cvld = 4'($urandom_range(0, 15));
      v.exp  = model(v.mode, v.key, v.cand, v.cvld);
      return v;
   endfunction

   vec_t tbl[8];
   vec_t hitv, bpv[5];
   int k, guard;

   initial begin
      tbl[0] = '{M_EQ,  32'h1234_5678, {32'h9, 32'h1234_5678, 32'h1234_5678, 32'h0}, 4'hF, '{4'b0110, 1'b1, 2'd1, 1'b1}};
      tbl[1] = '{M_LTU, 32'h1, {32'h5, 32'h1, 32'h1, 32'hFFFF_FFFF}, 4'hF, '{4'b0000, 1'b0, 2'd0, 1'b0}};
      tbl[2] = '{M_LT,  32'h1, {32'h5, 32'h1, 32'h1, 32'hFFFF_FFFF}, 4'hF, '{4'b0001, 1'b1, 2'd0, 1'b0}};
      tbl[3] = '{M_NE,  32'h1, {32'h5, 32'h1, 32'h1, 32'hFFFF_FFFF}, 4'hE, '{4'b1000, 1'b1, 2'd3, 1'b0}};
      tbl[4] = '{M_EQ,  32'hAAAA_5555, {4{32'hAAAA_5555}}, 4'h0, '{4'b0000, 1'b0, 2'd0, 1'b0}};
      tbl[5] = '{M_LT,  32'h0, {32'hFFFF_FFFE, 32'h8000_0000, 32'h1, 32'h0}, 4'hF, '{4'b1100, 1'b1, 2'd2, 1'b1}};
      tbl[6] = '{M_LTU, 32'h8000_0000, {32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF}, 4'hF, '{4'b1001, 1'b1, 2'd0, 1'b1}};
      tbl[7] = '{M_NE,  32'h3, {32'h3, 32'h4, 32'h3, 32'h2}, 4'hF, '{4'b0101, 1'b1, 2'd0, 1'b1}};
      hitv   = '{M_EQ,  32'hCAFE_0001, {32'h0, 32'h0, 32'h0, 32'hCAFE_0001}, 4'hF, '{4'b0001, 1'b1, 2'd0, 1'b0}};

      rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; cnt_clr = 1'b0;
      req_mode = '0; req_key = '0; req_cand = '0; req_cvld = '0;
      #1;
      chk("rst_outputs", 64'({rsp_valid, rsp_match, rsp_hit, rsp_idx, rsp_multi}), 64'd0);
      chk("rst_hit_cnt", 64'(hit_cnt), 64'd0);
      do_reset();
      chk("rst_req_ready", 64'(req_ready), 64'd1);

      foreach (tbl[i]) send_one(tbl[i], $sformatf("tbl%0d", i));
      @(posedge clk); #1;

      // Counter: three hits, clear coincident with a fourth, then saturation.
      do_reset();
      for (int i = 0; i < 3; i++) send_one(hitv, "cnt");
      @(posedge clk); #1;
      chk("cnt_three", 64'(hit_cnt), 64'd3);
      chk("cnt_three_sat", 64'(s_hit_cnt), 64'd3);
      send_one(hitv, "cnt4");
      cnt_clr = 1'b1;
      @(posedge clk); #1;
      cnt_clr = 1'b0;
      chk("cnt_clr_wins", 64'(hit_cnt), 64'd0);
      chk("cnt_clr_wins_sat", 64'(s_hit_cnt), 64'd0);
      for (int i = 0; i < 5; i++) send_one(hitv, "cnt5");
      @(posedge clk); #1;
      chk("cnt_five", 64'(hit_cnt), 64'd5);
      chk("cnt_saturate", 64'(s_hit_cnt), 64'd3);

      // Backpressure: five requests streamed into a stalled output.
      for (int i = 0; i < 5; i++) bpv[i] = rand_vec();
      bpv[0] = hitv;
      k = n_rsp;
      rsp_ready = 1'b0;
      guard = 0;
      for (int c = 0; c < 4; c++) begin
         drive(bpv[guard]);
         @(negedge clk);
         if (req_valid && req_ready) guard++;
         @(posedge clk); #1;
      end
      chk("bp_accepts", 64'(guard), 64'd2);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      rsp_ready = 1'b1;
      for (int c = 0; c < 30 && guard < 5; c++) begin
         drive(bpv[guard]);
         @(negedge clk);
         if (req_valid && req_ready) guard++;
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      for (int c = 0; c < 10; c++) begin @(posedge clk); #1; end
      chk("bp_all_rsp", 64'(n_rsp - k), 64'd5);

      // Reset with two requests in flight.
      rsp_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         drive(hitv);
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      chk("inflight_valid", 64'(rsp_valid), 64'd1);
      chk("inflight_cnt_nonzero", 64'(hit_cnt != 0), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_valid", 64'(rsp_valid), 64'd0);
      chk("midrst_cnt", 64'(hit_cnt), 64'd0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         chk("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
      end

      // Randomized stream with random backpressure and occasional clears.
      req_valid = 1'b0;
      for (int c = 0; c < 600; c++) begin
         if (!req_valid || (req_valid && k == 1)) begin
            if ($urandom_range(0, 3) != 0) drive(rand_vec());
            else req_valid = 1'b0;
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         cnt_clr   = ($urandom_range(0, 50) == 0);
         @(negedge clk);
         k = (req_valid && req_ready) ? 1 : 0;
         @(posedge clk); #1;
      end
      req_valid = 1'b0; cnt_clr = 1'b0; rsp_ready = 1'b1;
      guard = 0;
      while (exp_q.size() != 0 && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      chk("drain_empty", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
